// File: rtl/xif_offload_master_if.sv
// Core-side request/response and coprocessor issue/commit/result channels of the offload master.
interface xif_offload_master_if #(
  parameter int ID_WIDTH = 4
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [31:0]         req_instr_i;
  logic [31:0]         req_rs1_i;
  logic [31:0]         req_rs2_i;
  logic [ID_WIDTH-1:0] req_id_i;
  logic                kill_i;

  logic                x_issue_valid_o;
  logic                x_issue_ready_i;
  logic [31:0]         x_issue_instr_o;
  logic [63:0]         x_issue_rs_o;
  logic [1:0]          x_issue_rs_valid_o;
  logic [ID_WIDTH-1:0] x_issue_id_o;
  logic                x_issue_accept_i;
  logic                x_issue_writeback_i;

  logic                x_commit_valid_o;
  logic [ID_WIDTH-1:0] x_commit_id_o;
  logic                x_commit_kill_o;

  logic                x_result_valid_i;
  logic                x_result_ready_o;
  logic [ID_WIDTH-1:0] x_result_id_i;
  logic [31:0]         x_result_data_i;
  logic [4:0]          x_result_rd_i;
  logic                x_result_we_i;

  logic                rsp_valid_o;
  logic [31:0]         rsp_data_o;
  logic [4:0]          rsp_rd_o;
  logic                rsp_we_o;
  logic                rsp_illegal_o;
  logic                rsp_timeout_o;

  modport master (
    input  req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_id_i, kill_i,
           x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
           x_result_valid_i, x_result_id_i, x_result_data_i, x_result_rd_i, x_result_we_i,
    output req_ready_o, x_issue_valid_o, x_issue_instr_o, x_issue_rs_o, x_issue_rs_valid_o,
           x_issue_id_o, x_commit_valid_o, x_commit_id_o, x_commit_kill_o, x_result_ready_o,
           rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_we_o, rsp_illegal_o, rsp_timeout_o
  );

  modport slave (
    output req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_id_i, kill_i,
           x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
           x_result_valid_i, x_result_id_i, x_result_data_i, x_result_rd_i, x_result_we_i,
    input  req_ready_o, x_issue_valid_o, x_issue_instr_o, x_issue_rs_o, x_issue_rs_valid_o,
           x_issue_id_o, x_commit_valid_o, x_commit_id_o, x_commit_kill_o, x_result_ready_o,
           rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_we_o, rsp_illegal_o, rsp_timeout_o
  );
endinterface

// File: rtl/xif_offload_master.sv
// Single-outstanding coprocessor offload master: issue, commit, wait for result, respond to core.
module xif_offload_master #(
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  xif_offload_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, COMMIT, WAIT_RES, RESP} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         rs1_q, rs1_d;
  logic [31:0]         rs2_q, rs2_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                wb_q, wb_d;
  logic                kill_q, kill_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic [4:0]          rsp_rd_q, rsp_rd_d;
  logic                rsp_we_q, rsp_we_d;
  logic                rsp_illegal_q, rsp_illegal_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic res_match;
  logic timeout_hit;

  assign res_match   = bus.x_result_valid_i && (bus.x_result_id_i == id_q);
  assign timeout_hit = (cnt_q == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      id_q          <= '0;
      wb_q          <= 1'b0;
      kill_q        <= 1'b0;
      cnt_q         <= '0;
      rsp_data_q    <= '0;
      rsp_rd_q      <= '0;
      rsp_we_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      id_q          <= id_d;
      wb_q          <= wb_d;
      kill_q        <= kill_d;
      cnt_q         <= cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_we_q      <= rsp_we_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    id_d          = id_q;
    wb_d          = wb_q;
    kill_d        = kill_q;
    cnt_d         = cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_we_d      = rsp_we_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          instr_d = bus.req_instr_i;
          rs1_d   = bus.req_rs1_i;
          rs2_d   = bus.req_rs2_i;
          id_d    = bus.req_id_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.kill_i) kill_d = 1'b1;
        if (bus.x_issue_ready_i) begin
          if (bus.x_issue_accept_i) begin
            wb_d    = bus.x_issue_writeback_i;
            state_d = COMMIT;
          end else begin
            rsp_data_d    = '0;
            rsp_rd_d      = '0;
            rsp_we_d      = 1'b0;
            rsp_illegal_d = 1'b1;
            rsp_timeout_d = 1'b0;
            state_d       = RESP;
          end
        end
      end
      COMMIT: begin
        if (bus.kill_i) kill_d = 1'b1;
        if (kill_q || bus.kill_i) begin
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        cnt_d = cnt_q + 16'd1;
        // A matching result in the final counted cycle takes priority over the timeout.
        if (res_match) begin
          rsp_data_d    = bus.x_result_data_i;
          rsp_rd_d      = bus.x_result_rd_i;
          rsp_we_d      = bus.x_result_we_i & wb_q;
          rsp_illegal_d = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timeout_hit) begin
          rsp_data_d    = '0;
          rsp_rd_d      = '0;
          rsp_we_d      = 1'b0;
          rsp_illegal_d = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE && state_q != IDLE) kill_d = 1'b0;
  end

  always_comb begin
    bus.req_ready_o        = (state_q == IDLE);
    bus.x_issue_valid_o    = (state_q == ISSUE);
    bus.x_issue_instr_o    = instr_q;
    bus.x_issue_rs_o       = {rs2_q, rs1_q};
    bus.x_issue_rs_valid_o = (state_q == ISSUE) ? 2'b11 : 2'b00;
    bus.x_issue_id_o       = id_q;
    bus.x_commit_valid_o   = (state_q == COMMIT);
    bus.x_commit_id_o      = id_q;
    bus.x_commit_kill_o    = (state_q == COMMIT) && (kill_q || bus.kill_i);
    bus.x_result_ready_o   = (state_q == WAIT_RES);
    bus.rsp_valid_o        = (state_q == RESP);
    bus.rsp_data_o         = rsp_data_q;
    bus.rsp_rd_o           = rsp_rd_q;
    bus.rsp_we_o           = rsp_we_q;
    bus.rsp_illegal_o      = rsp_illegal_q;
    bus.rsp_timeout_o      = rsp_timeout_q;
  end

endmodule
